// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RV32I multicycle control unit: opcode constants,
// FSM state encodings, ALUOp/ALUControl codes and datapath mux select codes.
package riscv_ctrl_pkg;

  localparam int unsigned OP_W = 7;  // opcode field width, fixed by the ISA
  localparam int unsigned ST_W = 4;  // state register width

  localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

  typedef enum logic [ST_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic op_supported(input logic [OP_W-1:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
           (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/riscv_mc_control_if.sv
// Control-unit <-> datapath bundle.
//   master: control unit (reads instruction fields and zero, drives controls)
//   slave : datapath side (drives instruction fields and zero, reads controls)
interface riscv_mc_control_if;
  import riscv_ctrl_pkg::*;

  logic [OP_W-1:0] op;
  logic [2:0]      funct3;
  logic            funct7b5;
  logic            zero;
  logic            PCWrite;
  logic            AdrSrc;
  logic            MemWrite;
  logic            IRWrite;
  logic [1:0]      ResultSrc;
  logic [2:0]      ALUControl;
  logic [1:0]      ALUSrcA;
  logic [1:0]      ALUSrcB;
  logic [1:0]      ImmSrc;
  logic            RegWrite;
  logic            instr_done;
  logic            illegal;
  logic [ST_W-1:0] state_dbg;

  modport master (
    input  op, funct3, funct7b5, zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, instr_done, illegal, state_dbg
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl, ALUSrcA, ALUSrcB,
           ImmSrc, RegWrite, instr_done, illegal, state_dbg
  );

endinterface

// File: rtl/riscv_alu_decoder.sv
// ALU decoder: maps ALUOp/funct3/op[5]/funct7b5 to ALUControl.
//   alu_op_i, funct3_i, op5_i, funct7b5_i : decode inputs
//   alu_control_o                         : ALU operation code
//   funct_illegal_o                       : funct3 is not one of add/sub, slt, or, and
module riscv_alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_e    alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o,
  output logic       funct_illegal_o
);

  // Reported independently of alu_op so the FSM can flag it while still in DECODE.
  assign funct_illegal_o = !((funct3_i == 3'b000) || (funct3_i == 3'b010) ||
                             (funct3_i == 3'b110) || (funct3_i == 3'b111));

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // op5 separates R-type from immediate forms: addi never subtracts.
          3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_mc_control.sv
// Multicycle control unit for the RV32I datapath.
//   clk   : rising-edge clock
//   clr_n : asynchronous active-low reset (forces FETCH)
//   bus   : instruction fields and zero in; datapath controls, instr_done,
//           illegal and state_dbg out
module riscv_mc_control
  import riscv_ctrl_pkg::*;
(
  input logic               clk,
  input logic               clr_n,
  riscv_mc_control_if.master bus
);

  state_e     state_q, state_d;
  alu_op_e    alu_op;
  logic       pc_update;
  logic       branch;
  logic       funct_illegal;
  logic [2:0] alu_control;
  logic       is_alu_op;

  assign is_alu_op = (bus.op == OP_R) || (bus.op == OP_I);

  riscv_alu_decoder u_alu_decoder (
    .alu_op_i        (alu_op),
    .funct3_i        (bus.funct3),
    .op5_i           (bus.op[5]),
    .funct7b5_i      (bus.funct7b5),
    .alu_control_o   (alu_control),
    .funct_illegal_o (funct_illegal)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and Moore decode of the current state.
  always_comb begin
    state_d        = S_FETCH;
    alu_op         = ALUOP_ADD;
    pc_update      = 1'b0;
    branch         = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.ResultSrc  = RES_ALUOUT;
    bus.ALUSrcA    = SRCA_PC;
    bus.ALUSrcB    = SRCB_RD2;
    bus.RegWrite   = 1'b0;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        bus.IRWrite   = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        pc_update     = 1'b1;
        state_d       = S_DECODE;
      end
      S_DECODE: begin
        // Speculative branch target: OldPC + ImmExt.
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
        bus.illegal = !op_supported(bus.op) || (is_alu_op && funct_illegal);
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = SRCA_RD1;
        bus.ALUSrcB = SRCB_IMM;
        if (bus.op == OP_LW) begin
          state_d = S_MEMREAD;
        end else if (bus.op == OP_SW) begin
          state_d = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        bus.AdrSrc = 1'b1;
        state_d    = S_MEMWB;
      end
      S_MEMWB: begin
        bus.ResultSrc  = RES_DATA;
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        bus.AdrSrc     = 1'b1;
        bus.MemWrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_EXECUTER: begin
        bus.ALUSrcA = SRCA_RD1;
        bus.ALUSrcB = SRCB_RD2;
        alu_op      = ALUOP_FUNCT;
        state_d     = S_ALUWB;
      end
      S_EXECUTEI: begin
        bus.ALUSrcA = SRCA_RD1;
        bus.ALUSrcB = SRCB_IMM;
        alu_op      = ALUOP_FUNCT;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_BEQ: begin
        bus.ALUSrcA    = SRCA_RD1;
        bus.ALUSrcB    = SRCB_RD2;
        alu_op         = ALUOP_SUB;
        branch         = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_JAL: begin
        // PC takes the jump target computed in DECODE; ALU forms the link value.
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_FOUR;
        pc_update   = 1'b1;
        state_d     = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    case (bus.op)
      OP_SW:   bus.ImmSrc = IMM_S;
      OP_BEQ:  bus.ImmSrc = IMM_B;
      OP_JAL:  bus.ImmSrc = IMM_J;
      default: bus.ImmSrc = IMM_I;
    endcase
  end

  assign bus.PCWrite    = pc_update || (branch && bus.zero);
  assign bus.ALUControl = alu_control;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_riscv_mc_control.sv
module tb_riscv_mc_control;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] res;
    logic [2:0] aluc;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] imm;
    logic       regw;
    logic       done;
    logic       ill;
  } exp_t;

  typedef struct {
    string name;
    exp_t  exp;
  } sb_t;

  logic clk;
  logic clr_n;
  int   n_tests;
  int   n_fail;
  sb_t  sb_q[$];

  riscv_mc_control_if bus ();

  riscv_mc_control dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected outputs per state, written from the control table.
  function automatic exp_t model(input logic [3:0] st, input logic [6:0] op,
                                 input logic [2:0] f3, input logic f7, input logic z);
    exp_t e;
    logic legal_op;
    logic legal_f3;
    logic [2:0] fn;
    e        = '0;
    e.st     = st;
    legal_op = (op == 7'b0000011) || (op == 7'b0100011) || (op == 7'b0110011) ||
               (op == 7'b0010011) || (op == 7'b1100011) || (op == 7'b1101111);
    legal_f3 = (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    case (f3)
      3'b000:  fn = (op[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  fn = 3'b101;
      3'b110:  fn = 3'b011;
      3'b111:  fn = 3'b010;
      default: fn = 3'b000;
    endcase
    case (op)
      7'b0100011: e.imm = 2'b01;
      7'b1100011: e.imm = 2'b10;
      7'b1101111: e.imm = 2'b11;
      default:    e.imm = 2'b00;
    endcase
    case (st)
      4'd0:  begin e.irw = 1; e.pcw = 1; e.srcb = 2'b10; e.res = 2'b10; end
      4'd1:  begin
        e.srca = 2'b01; e.srcb = 2'b01;
        e.ill  = !legal_op || (((op == 7'b0110011) || (op == 7'b0010011)) && !legal_f3);
      end
      4'd2:  begin e.srca = 2'b10; e.srcb = 2'b01; end
      4'd3:  begin e.adr = 1; end
      4'd4:  begin e.res = 2'b01; e.regw = 1; e.done = 1; end
      4'd5:  begin e.adr = 1; e.memw = 1; e.done = 1; end
      4'd6:  begin e.srca = 2'b10; e.srcb = 2'b00; e.aluc = fn; end
      4'd7:  begin e.srca = 2'b10; e.srcb = 2'b01; e.aluc = fn; end
      4'd8:  begin e.regw = 1; e.done = 1; end
      4'd9:  begin e.srca = 2'b10; e.aluc = 3'b001; e.pcw = z; e.done = 1; end
      4'd10: begin e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t a;
    a.st   = bus.state_dbg;
    a.pcw  = bus.PCWrite;
    a.adr  = bus.AdrSrc;
    a.memw = bus.MemWrite;
    a.irw  = bus.IRWrite;
    a.res  = bus.ResultSrc;
    a.aluc = bus.ALUControl;
    a.srca = bus.ALUSrcA;
    a.srcb = bus.ALUSrcB;
    a.imm  = bus.ImmSrc;
    a.regw = bus.RegWrite;
    a.done = bus.instr_done;
    a.ill  = bus.illegal;
    return a;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_t  it;
      exp_t a;
      it = sb_q.pop_front();
      a  = sample();
      n_tests++;
      if (a !== it.exp) begin
        n_fail++;
        $display("FAIL %s state %0d: got 0x%h, expected 0x%h",
                 it.name, it.exp.st, a, it.exp);
      end
    end
  end

  task automatic push(input string name, input logic [3:0] st, input logic [6:0] op,
                      input logic [2:0] f3, input logic f7, input logic z);
    sb_t it;
    it.name = name;
    it.exp  = model(st, op, f3, f7, z);
    sb_q.push_back(it);
  endtask

  // Issue one instruction starting in FETCH; seq holds up to 5 states, n of them used.
  task automatic run(input string name, input logic [6:0] op, input logic [2:0] f3,
                     input logic f7, input logic z, input logic [3:0] seq [5], input int n);
    bus.op       = op;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
    bus.zero     = z;
    for (int i = 0; i < n; i++) push(name, seq[i], op, f3, f7, z);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] s [5];
    n_tests      = 0;
    n_fail       = 0;
    clr_n        = 1'b0;
    bus.op       = 7'b0000011;
    bus.funct3   = 3'b010;
    bus.funct7b5 = 1'b0;
    bus.zero     = 1'b1;

    // Reset holds FETCH decode.
    push("reset", 4'd0, 7'b0000011, 3'b010, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    clr_n = 1'b1;

    s = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    run("lw", 7'b0000011, 3'b010, 1'b0, 1'b0, s, 5);
    s = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    run("sw", 7'b0100011, 3'b010, 1'b0, 1'b1, s, 4);
    s = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
    run("sub", 7'b0110011, 3'b000, 1'b1, 1'b0, s, 4);
    run("and", 7'b0110011, 3'b111, 1'b0, 1'b0, s, 4);
    run("or", 7'b0110011, 3'b110, 1'b0, 1'b0, s, 4);
    run("r_bad_funct3", 7'b0110011, 3'b001, 1'b0, 1'b0, s, 4);
    s = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
    run("addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0, s, 4);
    run("slti", 7'b0010011, 3'b010, 1'b0, 1'b0, s, 4);
    s = '{4'd0, 4'd1, 4'd9, 4'd0, 4'd0};
    run("beq_taken", 7'b1100011, 3'b000, 1'b0, 1'b1, s, 3);
    run("beq_not_taken", 7'b1100011, 3'b000, 1'b0, 1'b0, s, 3);
    s = '{4'd0, 4'd1, 4'd10, 4'd8, 4'd0};
    run("jal", 7'b1101111, 3'b000, 1'b0, 1'b0, s, 4);
    s = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0};
    run("illegal_op", 7'b1111111, 3'b000, 1'b0, 1'b0, s, 2);

    // Asynchronous reset in MEMREAD: FETCH must appear before any clock edge.
    s = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd0};
    run("lw_pre_reset", 7'b0000011, 3'b010, 1'b0, 1'b0, s, 3);
    check("in_memread", 32'(bus.state_dbg), 32'd3);
    #1;
    clr_n = 1'b0;
    #1;
    check("async_reset_state", 32'(bus.state_dbg), 32'd0);
    check("async_reset_regwrite", 32'(bus.RegWrite), 32'd0);
    check("async_reset_irwrite", 32'(bus.IRWrite), 32'd1);
    @(posedge clk);
    #1;
    clr_n = 1'b1;

    s = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    run("sw_after_reset", 7'b0100011, 3'b010, 1'b0, 1'b0, s, 5);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
